// File: rtl/score_bcd_converter.sv
// score_bcd_converter: sequential double-dabble conversion of a clamped score into registered BCD digits
module score_bcd_converter #(
  parameter int SCORE_MAX = 999,
  parameter int CONV_BITS = 10,
  parameter int AUTO_UPDATE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] score,
  input  logic        start,
  output logic [3:0]  hundreds,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic        show_hundreds,
  output logic        show_tens,
  output logic        digits_valid,
  output logic        done,
  output logic        busy,
  output logic        overflow
);
  localparam int CW = $clog2(CONV_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [CONV_BITS-1:0] src;
  logic [11:0] bcd, adj;
  logic [31:0] last_score;
  logic ovf, launch, clamp;
  assign clamp = score > 32'(SCORE_MAX);
  assign launch = start || (AUTO_UPDATE != 0 && score != last_score);
  assign busy = state != IDLE;
  // add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    adj[11:8] = bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8];
    adj[7:4] = bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4];
    adj[3:0] = bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0];
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state: launch from IDLE, CONV_BITS shifts, one commit cycle
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (launch ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(CONV_BITS - 1) ? COMMIT : SHIFT) : IDLE;
  end
  // datapath: latch on launch, shift in SHIFT, publish digits only in COMMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      src <= '0;
      bcd <= '0;
      last_score <= '0;
      ovf <= 1'b0;
      hundreds <= '0;
      tens <= '0;
      ones <= '0;
      show_hundreds <= 1'b0;
      show_tens <= 1'b0;
      digits_valid <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= state == COMMIT;
      if (state == IDLE && launch) begin
        src <= clamp ? CONV_BITS'(SCORE_MAX) : score[CONV_BITS-1:0];
        ovf <= clamp;
        last_score <= score;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        {bcd, src} <= {adj, src} << 1;
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        hundreds <= bcd[11:8];
        tens <= bcd[7:4];
        ones <= bcd[3:0];
        show_hundreds <= bcd[11:8] != 4'd0;
        show_tens <= bcd[11:4] != 8'd0;
        digits_valid <= 1'b1;
        overflow <= ovf;
      end
    end
  end
endmodule
